systolic_data_setup: RTL

Skews row-ordered input vectors into the diagonal wavefront that `matrix_multiply_unit` consumes on its `systolic_data` / `systolic_signed` ports. Sits directly upstream of the MMU.
- Input: one full row of `MATRIX_WIDTH` bytes per cycle from the unified buffer read path.
- Output: lane i delayed by i extra cycles relative to lane 0, so column i of each row enters the array i cycles after column 0.
- Tracks per-lane validity, batch boundaries and a drain/busy status, so the control unit can sequence weight activation and result collection.

---
 rtl/systolic_data_setup.sv | 97 +++++++++
 1 files changed

// File: rtl/systolic_data_setup.sv
// Skews row-ordered byte vectors into the diagonal wavefront fed to the
// systolic array: lane i trails lane 0 by i cycles, with validity and batch tracking.

module systolic_lane #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy
);

  logic [DEPTH-1:0][7:0] r_data;
  logic [DEPTH-1:0]      r_vld_pipe;

  // Invalid slots carry a zero byte so the array never sees stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= '0;
      r_vld_pipe <= '0;
    end else if (i_enable) begin
      r_data[0]     <= i_valid ? i_data : 8'd0;
      r_vld_pipe[0] <= i_valid;
      for (int s = 1; s < DEPTH; s++) begin
        r_data[s]     <= r_data[s-1];
        r_vld_pipe[s] <= r_vld_pipe[s-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_vld_pipe[DEPTH-1];
  assign o_busy  = |r_vld_pipe;

endmodule

module systolic_data_setup #(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [MATRIX_WIDTH-1:0][7:0] data_in,
  input  logic                         data_in_signed,
  input  logic                         data_in_valid,
  input  logic                         data_in_last,
  output logic [MATRIX_WIDTH-1:0][7:0] systolic_data,
  output logic [MATRIX_WIDTH-1:0]      systolic_valid,
  output logic                         systolic_signed,
  output logic                         batch_done,
  output logic                         busy
);

  logic [MATRIX_WIDTH-1:0] w_lane_busy;
  logic [MATRIX_WIDTH-1:0] r_last_pipe;
  logic                    r_signed;

  // Lane g holds g+1 stages, giving the triangular skew.
  genvar g;
  generate
    for (g = 0; g < MATRIX_WIDTH; g++) begin : g_lane
      systolic_lane #(.DEPTH(g + 1)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .i_data   (data_in[g]),
        .i_valid  (data_in_valid),
        .o_data   (systolic_data[g]),
        .o_valid  (systolic_valid[g]),
        .o_busy   (w_lane_busy[g])
      );
    end
  endgenerate

  // Sign rides with lane 0; the last flag rides with the deepest lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_signed    <= 1'b0;
      r_last_pipe <= '0;
    end else if (enable) begin
      r_signed       <= data_in_valid & data_in_signed;
      r_last_pipe[0] <= data_in_valid & data_in_last;
      for (int s = 1; s < MATRIX_WIDTH; s++) begin
        r_last_pipe[s] <= r_last_pipe[s-1];
      end
    end
  end

  assign systolic_signed = r_signed;
  assign batch_done      = r_last_pipe[MATRIX_WIDTH-1] & systolic_valid[MATRIX_WIDTH-1];
  assign busy            = |w_lane_busy;

endmodule
